// File: rtl/register_bus_reader_pkg.sv
// Shared register-bus definitions: the reader FSM state encoding and the
// request field widths used by the reader and its bench.
package register_bus_reader_pkg;

    localparam int LenWidth  = 4;
    localparam int AddrWidth = 4;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        CAPTURE,
        RESPOND
    } state_e;

endpackage

// File: rtl/register_bus_reader_tick_down_counter.sv
// Loadable down-counter that only decrements on ticked cycles and stops at
// zero; the zero flag tells the reader its settle window has elapsed.
module tick_down_counter #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    output logic             zero
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/register_bus_reader.sv
// Burst reader for a shared tri-state register bus: selects one register at a
// time, waits a Tick-paced settle window, captures the bus and returns it.
module register_bus_reader
    import register_bus_reader_pkg::*;
#(
    parameter int NrOfBits     = 8,
    parameter int NrOfRegs     = 4,
    parameter int SettleCycles = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Tick,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic [AddrWidth-1:0] ReqAddr,
    input  logic [LenWidth-1:0]  ReqLen,
    output logic [NrOfRegs-1:0]  cs,
    input  logic [NrOfBits-1:0]  BusIn,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [NrOfBits-1:0]  RspData,
    output logic                 RspErr,
    output logic                 RspLast,
    output logic                 Busy
);

    localparam bit                   SkipSettle = (SettleCycles == 0);
    localparam logic [3:0]           SettleLoad = SkipSettle ? 4'd0 : 4'(SettleCycles - 1);
    localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(NrOfRegs - 1);
    localparam logic [AddrWidth:0]   RegCount   = (AddrWidth + 1)'(NrOfRegs);

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [LenWidth-1:0]   remain_q, remain_d;
    logic [NrOfBits-1:0]   data_q, data_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;
    logic                  accept;
    logic                  settle_zero;

    tick_down_counter #(
        .Width(4)
    ) u_settle (
        .clk       (Clock),
        .reset     (Reset),
        .tick      (Tick && (state_q == SETTLE)),
        .load      (Tick && (state_q == SELECT)),
        .load_value(SettleLoad),
        .zero      (settle_zero)
    );

    assign accept = ReqValid && (state_q == IDLE) && !Reset;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        data_d   = data_q;
        err_d    = err_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = ReqAddr;
                    remain_d = ReqLen;
                    // An out-of-range start aborts the whole burst with one error beat.
                    if ({1'b0, ReqAddr} >= RegCount) begin
                        state_d = RESPOND;
                        data_d  = '0;
                        err_d   = 1'b1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = SELECT;
                    end
                end
            end
            SELECT: begin
                if (Tick) begin
                    state_d = SkipSettle ? CAPTURE : SETTLE;
                end
            end
            SETTLE: begin
                if (Tick && settle_zero) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (Tick) begin
                    state_d = RESPOND;
                    data_d  = BusIn;
                    err_d   = 1'b0;
                    last_d  = (remain_q == '0);
                end
            end
            RESPOND: begin
                if (RspReady) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = SELECT;
                        addr_d   = (addr_q == LastAddr) ? '0 : addr_q + AddrWidth'(1);
                        remain_d = remain_q - LenWidth'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            err_q    <= err_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        cs = '1;
        if ((state_q == SELECT) || (state_q == SETTLE) || (state_q == CAPTURE)) begin
            for (int i = 0; i < NrOfRegs; i++) begin
                if (addr_q == AddrWidth'(i)) begin
                    cs[i] = 1'b0;
                end
            end
        end
    end

    assign ReqReady = (state_q == IDLE) && !Reset;
    assign RspValid = (state_q == RESPOND);
    assign RspData  = data_q;
    assign RspErr   = err_q;
    assign RspLast  = last_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: doc/register_bus_reader.md
REGISTER_BUS_READER -- requirements
Module: register_bus_reader

Interface
REQ-001 Parameters SHALL be:
  NrOfBits  8  width of the shared data bus
  NrOfRegs  4  number of tri-state registers on the bus, 1..16
  SettleCycles  1  ticked cycles between select and capture, 0..15
REQ-002 Ports SHALL be:
  Clock  in  1  single clock, all state updates on rising edge
  Reset  in  1  synchronous, active-high
  Tick  in  1  advance enable for bus-phase states
  ReqValid  in  1  read request valid
  ReqReady  out  1  request accepted when ReqValid&ReqReady
  ReqAddr  in  4  first register index
  ReqLen  in  4  burst length minus one, 1..16 beats
  cs  out  NrOfRegs  per-register select; 1 = deselected (register drives Z), 0 = drive bus
  BusIn  in  NrOfBits  shared tri-state data bus
  RspValid  out  1  response beat valid
  RspReady  in  1  response beat consumed when RspValid&RspReady
  RspData  out  NrOfBits  captured bus value
  RspErr  out  1  address out of range
  RspLast  out  1  final beat of burst
  Busy  out  1  1 whenever state is not IDLE

Function
REQ-003 The FSM SHALL have states IDLE, SELECT, SETTLE, CAPTURE, RESPOND.
REQ-004 ReqReady SHALL be 1 only in IDLE; on accept, ReqAddr and ReqLen SHALL be latched and state SHALL go to SELECT.
REQ-005 SELECT->SETTLE, SETTLE->CAPTURE, and CAPTURE->RESPOND SHALL occur only on edges with Tick=1; IDLE accept and RESPOND handshake SHALL ignore Tick.
REQ-006 SETTLE SHALL last exactly SettleCycles ticked cycles; with SettleCycles=0, SELECT SHALL go directly to CAPTURE.
REQ-007 In SELECT, SETTLE, and CAPTURE, cs[addr] SHALL be 0 and all other bits 1; in IDLE and RESPOND, cs SHALL be all ones; at most one cs bit SHALL be 0 at any time.
REQ-008 On the ticked edge leaving CAPTURE, BusIn SHALL be registered into RspData; with Tick constantly 1, RspValid SHALL rise 2+SettleCycles edges after the accepting edge.
REQ-009 RspValid, RspData, RspErr, and RspLast SHALL hold stable in RESPOND until RspReady=1.
REQ-010 On a response handshake with beats remaining, addr SHALL increment, wrapping from NrOfRegs-1 to 0, and state SHALL go to SELECT; on the last beat, state SHALL go to IDLE.
REQ-011 RspLast SHALL be 1 only on beat ReqLen+1 or on an error beat.
REQ-012 If the latched ReqAddr >= NrOfRegs, no cs bit SHALL assert, state SHALL go directly to RESPOND with RspErr=1, RspData=0, RspLast=1, and the burst SHALL be aborted.
REQ-013 A new request SHALL be accepted no earlier than the cycle after the final response handshake, because ReqReady=0 in RESPOND.

Reset
REQ-014 Reset SHALL override all other inputs, including Tick, on the edge where it is sampled high.
REQ-015 After reset: state IDLE; cs all ones; ReqReady 1 once Reset=0; RspValid, RspData, RspErr, RspLast, and Busy all 0.
REQ-016 Reset mid-burst SHALL drop the burst silently, with no response emitted afterward.

Structure
REQ-017 The state encoding and the ReqLen width (4) SHALL reside in the shared register-bus package.
REQ-018 The settle count SHALL be implemented as one sub-module, tick_down_counter: a loadable Tick-gated down-counter with a zero flag.

Verification
Bench setup: NrOfBits=8, NrOfRegs=4, SettleCycles=1, tri-state register models holding 0x11, 0x22, 0x33, 0x44.
REQ-019 Single read, addr=2, len=0, Tick=1, RspReady=1 -> cs=1011 for 3 cycles, RspValid 3 edges after accept, RspData=0x33, RspLast=1, RspErr=0.
REQ-020 Burst, addr=3, len=2 -> beats 0x44, 0x11, 0x22 with wrap; RspLast only on the third beat; cs order 0111, 1110, 1101.
REQ-021 Tick high every third cycle, addr=1 -> RspData=0x22; cs low for 9 cycles; no state advance on Tick=0 cycles.
REQ-022 RspReady low for 5 cycles -> RspValid and RspData stable; cs=1111; ReqReady=0; Busy=1 throughout.
REQ-023 Reset pulsed during SETTLE of a 4-beat burst -> next cycle cs=1111, RspValid=0, Busy=0; no stale beat after release.
REQ-024 NrOfRegs=3, addr=3 -> cs never low; the edge after accept gives RspValid=1, RspErr=1, RspData=0x00, RspLast=1.
